fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage. It owns the PC and boots from a reset-vector word held in instruction memory. It supports one- and two-word instructions, branch redirect, pipeline stall and vectored interrupts, and drives the registered IF/ID pipeline outputs. It sits between the synchronous-read-free (combinational) instruction memory and the decode stage.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 16, instruction/memory word width
- RESET_PTR, 0, memory address holding the reset vector
- INT_PTR, 1, memory address holding the interrupt vector
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  hold PC and outputs (decode back-pressure)
- i_branch_taken  in  1  redirect request from execute
- i_branch_target  in  ADDR_W  redirect address
- i_interrupt  in  1  interrupt request, one-cycle pulse or level
- o_mem_addr  out  ADDR_W  instruction memory address (combinational)
- i_mem_data  in  INSTR_W  instruction memory read data, same cycle
- o_valid  out  1  IF/ID outputs hold a real instruction
- o_instr  out  INSTR_W  instruction word
- o_imm  out  INSTR_W  second word of a two-word instruction, else 0
- o_pc  out  ADDR_W  address of o_instr
- o_int_taken  out  1  this slot is an interrupt entry (decode pushes o_pc)

## Operation
- States: BOOT, RUN, IMM, INT_LOAD.
- BOOT: o_mem_addr=RESET_PTR; next edge PC<=zero-extended i_mem_data, go RUN; o_valid=0.
- RUN: o_mem_addr=PC.
  - If i_mem_data[INSTR_W-1]=1 (two-word): latch word into instr_hold, PC<=PC+1, go IMM, o_valid<=0.
  - Else: register outputs (o_instr=word, o_imm=0, o_pc=PC, o_valid=1), PC<=PC+1.
- IMM: o_mem_addr=PC; output {instr_hold, i_mem_data}, o_pc=PC-1, o_valid=1; PC<=PC+1; go RUN.
- Interrupt: i_interrupt sets int_pending. The interrupt is taken only in RUN, when not stalled and with no branch: o_int_taken<=1, o_pc<=PC (return address), o_valid<=0, go INT_LOAD; PC not incremented.
- INT_LOAD: o_mem_addr=INT_PTR; PC<=zero-extended i_mem_data; clear int_pending; go RUN.
- Branch (any state except BOOT): PC<=i_branch_target, state<=RUN, outputs flushed (o_valid<=0, o_int_taken<=0). A half-fetched two-word instruction is discarded.
- Stall: PC, state, instr_hold and all outputs hold; o_mem_addr still driven.
- Priority: reset > BOOT > branch > INT_LOAD completion > stall > interrupt take > normal fetch.
- A branch during INT_LOAD aborts the load; int_pending stays set and is retaken at the target.
- PC arithmetic is modulo 2^ADDR_W; PC wraps from all-ones to 0 without a flag.

## Timing
- Reset values: PC=0, state=BOOT, int_pending=0, o_valid=0, o_instr=0, o_imm=0, o_pc=0, o_int_taken=0.
- Reset asserted mid-operation: all state returns to reset values on that edge.
- First instruction: BOOT cycle, then PC fetch cycle; o_valid=1 on the second edge after reset is released.
- Fetch latency: one cycle, address cycle n gives registered output at edge n+1.
- Throughput: one one-word instruction per cycle, one two-word instruction per two cycles.
- Branch penalty: one bubble; the target instruction is registered on the edge after the redirect edge.
- Interrupt entry: two bubble cycles (take, INT_LOAD) before the vector instruction is fetched.
- o_int_taken is a one-cycle pulse unless held by stall.

## Configuration
- FETCH_INTERRUPT_EN defined: interrupt logic, INT_LOAD state and o_int_taken are present as described.
- FETCH_INTERRUPT_EN undefined:
  - i_interrupt is ignored.
  - o_int_taken is tied 0.
  - INT_LOAD is unreachable and removed.
  - All other timing is identical.

## Structure
- Shared package fetch_pkg holds:
  - the state encoding constants (BOOT, RUN, IMM, INT_LOAD);
  - the two-word flag bit position (INSTR_W-1);
  - the default RESET_PTR and INT_PTR values.
- One sub-module, fetch_ctrl: next-state and PC-select logic (priority mux). fetch_unit keeps the PC, instr_hold and the IF/ID output registers.

## Test plan
- Reset vector: mem[0]=0x0020, mem[0x20]=0x1234, mem[0x21]=0x2222; release reset -> o_valid=1, o_pc=0x20, o_instr=0x1234 two edges later, then o_pc=0x21 next cycle.
- Two-word: mem[0x20]=0x8001, mem[0x21]=0x00FF, mem[0x22]=0x0000 -> one bubble, then o_instr=0x8001, o_imm=0x00FF, o_pc=0x20; next o_pc=0x22.
- Branch mid two-word: branch to 0x40 in the IMM cycle -> fetch of 0x8001 discarded, next valid o_pc=0x40.
- Interrupt: mem[1]=0x0100, pulse i_interrupt while fetching 0x25 -> o_int_taken=1 with o_pc=0x25, then a bubble, then o_pc=0x100 valid.
- Stall: assert i_stall 3 cycles at o_pc=0x22 -> outputs constant 3 cycles, then o_pc=0x23 the cycle after release.
- Interrupt + simultaneous branch to 0x50 -> branch wins; interrupt taken next cycle with o_pc=0x50.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - fetch_state_t : fetch FSM state encoding (BOOT, RUN, IMM, INT_LOAD)
//   - pc_sel_t      : next-PC source chosen by fetch_ctrl
//   - out_sel_t     : IF/ID output register action chosen by fetch_ctrl
//   - addr_sel_t    : instruction memory address source
//   - DEFAULT_RESET_PTR / DEFAULT_INT_PTR : default vector locations
//   - two_word_bit() : bit position of the two-word instruction flag
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    IMM      = 2'd2,
    INT_LOAD = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_MEM,
    PC_BRANCH
  } pc_sel_t;

  typedef enum logic [2:0] {
    OUT_HOLD,    // keep every IF/ID register
    OUT_BUBBLE,  // o_valid/o_int_taken low, data fields keep last value
    OUT_ONE,     // one-word instruction straight from memory
    OUT_TWO,     // held first word plus immediate from memory
    OUT_INT      // interrupt entry slot carrying the return address
  } out_sel_t;

  typedef enum logic [1:0] {
    ADDR_PC,
    ADDR_RESET,
    ADDR_INT
  } addr_sel_t;

  localparam int DEFAULT_RESET_PTR = 0;
  localparam int DEFAULT_INT_PTR   = 1;

  // The top bit of the first word marks a two-word instruction.
  function automatic int two_word_bit(input int instr_w);
    return instr_w - 1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: combinational next-state / PC-select priority mux.
// Optional feature macro: FETCH_INTERRUPT_EN (interrupt take and INT_LOAD).
// Ports:
//   i_state        current fetch state
//   i_stall        decode back-pressure
//   i_branch_taken redirect request
//   i_int_req      pending or newly requested interrupt
//   i_two_word     current memory word carries the two-word flag
//   o_next_state   state for the next edge
//   o_pc_sel       next-PC source
//   o_out_sel      IF/ID register action
//   o_addr_sel     instruction memory address source
//   o_hold_en      capture the first word of a two-word instruction
//   o_int_clear    clear the pending interrupt (vector load completes)
module fetch_ctrl
  import fetch_pkg::*;
(
  input  fetch_state_t i_state,
  input  logic         i_stall,
  input  logic         i_branch_taken,
  input  logic         i_int_req,
  input  logic         i_two_word,
  output fetch_state_t o_next_state,
  output pc_sel_t      o_pc_sel,
  output out_sel_t     o_out_sel,
  output addr_sel_t    o_addr_sel,
  output logic         o_hold_en,
  output logic         o_int_clear
);

`ifndef FETCH_INTERRUPT_EN
  logic w_unused_int_req;
  assign w_unused_int_req = i_int_req;
`endif

  always_comb begin
    case (i_state)
      BOOT:     o_addr_sel = ADDR_RESET;
      INT_LOAD: o_addr_sel = ADDR_INT;
      default:  o_addr_sel = ADDR_PC;
    endcase
  end

  // Priority: BOOT > branch > INT_LOAD completion > stall > interrupt take
  // > normal fetch. Reset is handled by the registers in the top.
  always_comb begin
    o_next_state = i_state;
    o_pc_sel     = PC_HOLD;
    o_out_sel    = OUT_HOLD;
    o_hold_en    = 1'b0;
    o_int_clear  = 1'b0;
    if (i_state == BOOT) begin
      o_next_state = RUN;
      o_pc_sel     = PC_MEM;
      o_out_sel    = OUT_BUBBLE;
    end else if (i_branch_taken) begin
      // Discards any half-fetched two-word instruction or vector load.
      o_next_state = RUN;
      o_pc_sel     = PC_BRANCH;
      o_out_sel    = OUT_BUBBLE;
`ifdef FETCH_INTERRUPT_EN
    end else if (i_state == INT_LOAD) begin
      o_next_state = RUN;
      o_pc_sel     = PC_MEM;
      o_out_sel    = OUT_BUBBLE;
      o_int_clear  = 1'b1;
`endif
    end else if (i_stall) begin
      o_next_state = i_state;
`ifdef FETCH_INTERRUPT_EN
    end else if (i_state == RUN && i_int_req) begin
      // PC is left pointing at the instruction that was not executed.
      o_next_state = INT_LOAD;
      o_out_sel    = OUT_INT;
`endif
    end else begin
      case (i_state)
        RUN: begin
          o_pc_sel = PC_INC;
          if (i_two_word) begin
            o_next_state = IMM;
            o_out_sel    = OUT_BUBBLE;
            o_hold_en    = 1'b1;
          end else begin
            o_next_state = RUN;
            o_out_sel    = OUT_ONE;
          end
        end
        IMM: begin
          o_next_state = RUN;
          o_pc_sel     = PC_INC;
          o_out_sel    = OUT_TWO;
        end
        default: begin
          // Only reachable from an unused encoding: recover into RUN.
          o_next_state = RUN;
          o_out_sel    = OUT_BUBBLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with reset vector, two-word
// instructions, branch redirect, stall and (optionally) vectored interrupts.
// Optional feature macro: FETCH_INTERRUPT_EN. Undefined: i_interrupt is
// ignored and o_int_taken is tied low.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_stall                 hold PC, state and outputs
//   i_branch_taken/_target  redirect request and address
//   i_interrupt             interrupt request (pulse or level)
//   o_mem_addr, i_mem_data  combinational instruction memory port
//   o_valid, o_instr, o_imm, o_pc, o_int_taken   registered IF/ID outputs
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                INSTR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PTR = ADDR_W'(DEFAULT_RESET_PTR),
  parameter logic [ADDR_W-1:0] INT_PTR   = ADDR_W'(DEFAULT_INT_PTR)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  input  logic               i_interrupt,
  output logic [ADDR_W-1:0]  o_mem_addr,
  input  logic [INSTR_W-1:0] i_mem_data,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [INSTR_W-1:0] o_imm,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_int_taken
);

  localparam int                FLAG_BIT = two_word_bit(INSTR_W);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr_hold;
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_imm;
  logic [ADDR_W-1:0]  r_out_pc;

  fetch_state_t w_next_state;
  pc_sel_t      w_pc_sel;
  out_sel_t     w_out_sel;
  addr_sel_t    w_addr_sel;
  logic         w_hold_en;
  logic         w_int_clear;
  logic         w_int_req;

  fetch_ctrl u_ctrl (
    .i_state        (r_state),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_int_req      (w_int_req),
    .i_two_word     (i_mem_data[FLAG_BIT]),
    .o_next_state   (w_next_state),
    .o_pc_sel       (w_pc_sel),
    .o_out_sel      (w_out_sel),
    .o_addr_sel     (w_addr_sel),
    .o_hold_en      (w_hold_en),
    .o_int_clear    (w_int_clear)
  );

  always_comb begin
    case (w_addr_sel)
      ADDR_RESET: o_mem_addr = RESET_PTR;
      ADDR_INT:   o_mem_addr = INT_PTR;
      default:    o_mem_addr = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= BOOT;
      r_pc         <= '0;
      r_instr_hold <= '0;
      r_valid      <= 1'b0;
      r_instr      <= '0;
      r_imm        <= '0;
      r_out_pc     <= '0;
    end else begin
      r_state <= w_next_state;
      case (w_pc_sel)
        PC_INC:    r_pc <= r_pc + PC_ONE;
        PC_MEM:    r_pc <= ADDR_W'(i_mem_data);  // zero-extended vector
        PC_BRANCH: r_pc <= i_branch_target;
        default:   r_pc <= r_pc;
      endcase
      if (w_hold_en) begin
        r_instr_hold <= i_mem_data;
      end
      case (w_out_sel)
        OUT_BUBBLE: r_valid <= 1'b0;
        OUT_ONE: begin
          r_valid  <= 1'b1;
          r_instr  <= i_mem_data;
          r_imm    <= '0;
          r_out_pc <= r_pc;
        end
        OUT_TWO: begin
          // PC already advanced past the first word; report its address.
          r_valid  <= 1'b1;
          r_instr  <= r_instr_hold;
          r_imm    <= i_mem_data;
          r_out_pc <= r_pc - PC_ONE;
        end
        OUT_INT: begin
          r_valid  <= 1'b0;
          r_out_pc <= r_pc;
        end
        default: r_valid <= r_valid;
      endcase
    end
  end

`ifdef FETCH_INTERRUPT_EN
  logic r_int_pending;
  logic r_int_taken;

  // A request in the take cycle is served immediately.
  assign w_int_req = r_int_pending | i_interrupt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_int_pending <= 1'b0;
      r_int_taken   <= 1'b0;
    end else begin
      if (w_int_clear) begin
        r_int_pending <= 1'b0;
      end else if (i_interrupt) begin
        r_int_pending <= 1'b1;
      end
      case (w_out_sel)
        OUT_HOLD: r_int_taken <= r_int_taken;
        OUT_INT:  r_int_taken <= 1'b1;
        default:  r_int_taken <= 1'b0;
      endcase
    end
  end

  assign o_int_taken = r_int_taken;
`else
  logic w_unused_int;
  assign w_unused_int = i_interrupt | w_int_clear;
  assign w_int_req    = 1'b0;
  assign o_int_taken  = 1'b0;
`endif

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_imm   = r_imm;
  assign o_pc    = r_out_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Expected IF/ID slots are
// queued with the edge number on which they must appear; a monitor pops and
// compares every slot the DUT produces. Interrupt scenarios follow the
// FETCH_INTERRUPT_EN build option.
module tb_fetch_unit;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] imm;
    logic        intk;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        i_interrupt = 1'b0;
  logic [31:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic        o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_imm;
  logic [31:0] o_pc;
  logic        o_int_taken;

  logic [15:0] mem [0:511];
  exp_t        sb[$];
  int          edge_cnt = 0;
  int          base = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  fetch_unit dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_interrupt     (i_interrupt),
    .o_mem_addr      (o_mem_addr),
    .i_mem_data      (i_mem_data),
    .o_valid         (o_valid),
    .o_instr         (o_instr),
    .o_imm           (o_imm),
    .o_pc            (o_pc),
    .o_int_taken     (o_int_taken)
  );

  assign i_mem_data = mem[o_mem_addr[8:0]];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard monitor: every produced slot must match the queue front.
  always @(negedge clk) begin
    if (mon_en && (o_valid || o_int_taken)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_slot edge=%0d got pc=%h instr=%h int=%0b, required none",
                 edge_cnt - base, o_pc, o_instr, o_int_taken);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (edge_cnt != e.cyc || o_pc !== e.pc || o_int_taken !== e.intk ||
            o_valid !== !e.intk || (!e.intk && (o_instr !== e.instr || o_imm !== e.imm))) begin
          n_fail++;
          $display("FAIL slot got edge=%0d pc=%h instr=%h imm=%h valid=%0b int=%0b, required edge=%0d pc=%h instr=%h imm=%h int=%0b",
                   edge_cnt - base, o_pc, o_instr, o_imm, o_valid, o_int_taken,
                   e.cyc - base, e.pc, e.instr, e.imm, e.intk);
        end else begin
          $display("slot edge=%0d pc=%h instr=%h imm=%h int=%0b ok",
                   edge_cnt - base, o_pc, o_instr, o_imm, o_int_taken);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (edge_cnt < base + n && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  function automatic void expect_slot(input int n, input logic [31:0] pc,
                                      input logic [15:0] instr,
                                      input logic [15:0] imm, input logic intk);
    exp_t e;
    e.cyc = base + n; e.pc = pc; e.instr = instr; e.imm = imm; e.intk = intk;
    sb.push_back(e);
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'(16'h1000 + i);
    mem[0] = 16'h0020;
    mem[1] = 16'h0100;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    i_reset = 1'b1; i_stall = 1'b0; i_branch_taken = 1'b0;
    i_branch_target = '0; i_interrupt = 1'b0;
    tick();
    tick();
    sb.delete();
    base = edge_cnt;
    i_reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic end_test(input string name);
    mon_en = 1'b0;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_slots got %0d left, required 0 (next edge=%0d pc=%h)",
               name, sb.size(), sb[0].cyc - base, sb[0].pc);
    end else begin
      $display("%s complete", name);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    init_mem();
    do_reset();
    n_checks++;
    if ({o_valid, o_int_taken, o_instr, o_imm, o_pc} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%0b int=%0b instr=%h imm=%h pc=%h, required all 0",
               o_valid, o_int_taken, o_instr, o_imm, o_pc);
    end
    n_checks++;
    if (o_mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_boot_addr got %h, required 00000000", o_mem_addr);
    end
    expect_slot(2, 32'h20, 16'h1020, 16'h0, 1'b0);
    expect_slot(3, 32'h21, 16'h1021, 16'h0, 1'b0);
    run_to(3);
    // Mid-operation reset returns everything to reset values on that edge.
    i_reset = 1'b1;
    tick();
    n_checks++;
    if ({o_valid, o_int_taken, o_instr, o_imm, o_pc} !== '0 || o_mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midop_reset got valid=%0b instr=%h pc=%h addr=%h, required 0",
               o_valid, o_instr, o_pc, o_mem_addr);
    end
    i_reset = 1'b0;
    base = edge_cnt;
    expect_slot(2, 32'h20, 16'h1020, 16'h0, 1'b0);
    run_to(2);
    end_test("test_reset");
  endtask

  task automatic test_reset_vector();
    init_mem();
    mem[16'h20] = 16'h1234;
    mem[16'h21] = 16'h2222;
    do_reset();
    expect_slot(2, 32'h20, 16'h1234, 16'h0, 1'b0);
    expect_slot(3, 32'h21, 16'h2222, 16'h0, 1'b0);
    expect_slot(4, 32'h22, 16'h1022, 16'h0, 1'b0);
    run_to(4);
    end_test("test_reset_vector");
  endtask

  task automatic test_two_word();
    init_mem();
    mem[16'h20] = 16'h8001;
    mem[16'h21] = 16'h00FF;
    mem[16'h22] = 16'h0000;
    do_reset();
    expect_slot(3, 32'h20, 16'h8001, 16'h00FF, 1'b0);
    expect_slot(4, 32'h22, 16'h0000, 16'h0, 1'b0);
    expect_slot(5, 32'h23, 16'h1023, 16'h0, 1'b0);
    run_to(2);
    n_checks++;
    if (o_mem_addr !== 32'h21 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL two_word_imm_cycle got addr=%h valid=%0b, required 00000021 0",
               o_mem_addr, o_valid);
    end
    run_to(5);
    end_test("test_two_word");
  endtask

  task automatic test_back_to_back();
    init_mem();
    mem[16'h20] = 16'h8001; mem[16'h21] = 16'h0011;
    mem[16'h22] = 16'h8002; mem[16'h23] = 16'h0022;
    do_reset();
    expect_slot(3, 32'h20, 16'h8001, 16'h0011, 1'b0);
    expect_slot(5, 32'h22, 16'h8002, 16'h0022, 1'b0);
    expect_slot(6, 32'h24, 16'h1024, 16'h0, 1'b0);
    expect_slot(7, 32'h25, 16'h1025, 16'h0, 1'b0);
    run_to(7);
    end_test("test_back_to_back");
  endtask

  task automatic test_branch_mid_two_word();
    init_mem();
    mem[16'h20] = 16'h8001;
    mem[16'h21] = 16'h00FF;
    do_reset();
    expect_slot(4, 32'h40, 16'h1040, 16'h0, 1'b0);
    expect_slot(5, 32'h41, 16'h1041, 16'h0, 1'b0);
    run_to(2);
    i_branch_taken = 1'b1; i_branch_target = 32'h40;
    tick();
    i_branch_taken = 1'b0;
    run_to(5);
    end_test("test_branch_mid_two_word");
  endtask

  task automatic test_stall();
    init_mem();
    do_reset();
    expect_slot(2, 32'h20, 16'h1020, 16'h0, 1'b0);
    expect_slot(3, 32'h21, 16'h1021, 16'h0, 1'b0);
    for (int k = 4; k <= 7; k++) expect_slot(k, 32'h22, 16'h1022, 16'h0, 1'b0);
    expect_slot(8, 32'h23, 16'h1023, 16'h0, 1'b0);
    run_to(4);
    i_stall = 1'b1;
    tick();
    n_checks++;
    if (o_mem_addr !== 32'h23) begin
      n_fail++;
      $display("FAIL stall_mem_addr got %h, required 00000023", o_mem_addr);
    end
    tick();
    tick();
    i_stall = 1'b0;
    run_to(8);
    end_test("test_stall");
  endtask

  task automatic test_interrupt();
    init_mem();
    do_reset();
    for (int k = 2; k <= 6; k++) expect_slot(k, 32'(32'h1E + k), 16'(16'h101E + k), 16'h0, 1'b0);
`ifdef FETCH_INTERRUPT_EN
    expect_slot(7, 32'h25, 16'h0, 16'h0, 1'b1);
    expect_slot(9, 32'h100, 16'h1100, 16'h0, 1'b0);
    expect_slot(10, 32'h101, 16'h1101, 16'h0, 1'b0);
`else
    expect_slot(7, 32'h25, 16'h1025, 16'h0, 1'b0);
    expect_slot(8, 32'h26, 16'h1026, 16'h0, 1'b0);
`endif
    run_to(6);
    i_interrupt = 1'b1;
    tick();
    i_interrupt = 1'b0;
`ifdef FETCH_INTERRUPT_EN
    n_checks++;
    if (o_mem_addr !== 32'h1) begin
      n_fail++;
      $display("FAIL int_load_addr got %h, required 00000001", o_mem_addr);
    end
    run_to(10);
`else
    run_to(8);
`endif
    end_test("test_interrupt");
  endtask

  task automatic test_int_with_branch();
    init_mem();
    do_reset();
    expect_slot(2, 32'h20, 16'h1020, 16'h0, 1'b0);
    expect_slot(3, 32'h21, 16'h1021, 16'h0, 1'b0);
`ifdef FETCH_INTERRUPT_EN
    expect_slot(5, 32'h50, 16'h0, 16'h0, 1'b1);
    expect_slot(7, 32'h100, 16'h1100, 16'h0, 1'b0);
`else
    expect_slot(5, 32'h50, 16'h1050, 16'h0, 1'b0);
    expect_slot(6, 32'h51, 16'h1051, 16'h0, 1'b0);
`endif
    run_to(3);
    i_interrupt = 1'b1; i_branch_taken = 1'b1; i_branch_target = 32'h50;
    tick();
    i_interrupt = 1'b0; i_branch_taken = 1'b0;
`ifdef FETCH_INTERRUPT_EN
    run_to(7);
`else
    run_to(6);
`endif
    end_test("test_int_with_branch");
  endtask

  task automatic test_branch_aborts_int_load();
    init_mem();
    do_reset();
    expect_slot(2, 32'h20, 16'h1020, 16'h0, 1'b0);
    expect_slot(3, 32'h21, 16'h1021, 16'h0, 1'b0);
`ifdef FETCH_INTERRUPT_EN
    expect_slot(4, 32'h22, 16'h0, 16'h0, 1'b1);
    expect_slot(6, 32'h60, 16'h0, 16'h0, 1'b1);
    expect_slot(8, 32'h100, 16'h1100, 16'h0, 1'b0);
`else
    expect_slot(4, 32'h22, 16'h1022, 16'h0, 1'b0);
    expect_slot(6, 32'h60, 16'h1060, 16'h0, 1'b0);
    expect_slot(7, 32'h61, 16'h1061, 16'h0, 1'b0);
`endif
    run_to(3);
    i_interrupt = 1'b1;
    tick();
    i_interrupt = 1'b0;
    i_branch_taken = 1'b1; i_branch_target = 32'h60;
    tick();
    i_branch_taken = 1'b0;
`ifdef FETCH_INTERRUPT_EN
    run_to(8);
`else
    run_to(7);
`endif
    end_test("test_branch_aborts_int_load");
  endtask

  initial begin
    test_reset();
    test_reset_vector();
    test_two_word();
    test_back_to_back();
    test_branch_mid_two_word();
    test_stall();
    test_interrupt();
    test_int_with_branch();
    test_branch_aborts_int_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
